// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that assembles an AES command frame (mode byte, key,
// plaintext) and hands it to KeyExpansion/Cipher, holding cs until Cipher
// reports completion through flag.
module spi_frame_loader #(
  parameter int SYNC_STAGES = 2  // synchronizer depth, must be at least 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_sclk,
  input  logic         spi_mosi,
  input  logic         spi_ss_n,
  input  logic         flag,
  output logic [3:0]   Nk,
  output logic [3:0]   Nr,
  output logic [255:0] key,
  output logic [127:0] init,
  output logic         cs,
  output logic         busy,
  output logic         frame_err
);

  typedef enum logic [2:0] {IDLE, MODE, KEY, DATA, RUN, ERR} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_hist, ss_hist;
  logic sclk_s, mosi_s, ss_s;
  logic sample, ss_fall, ss_rise, in_frame, byte_done;

  logic [6:0]   shift;
  logic [2:0]   bit_cnt;
  logic [4:0]   byte_cnt;
  logic [7:0]   rx_byte;
  logic [3:0]   nk_stage, nr_stage;
  logic [255:0] key_stage;
  logic [119:0] init_stage;  // plaintext bytes 0..14; byte 15 goes straight to init
  logic [5:0]   key_bytes;
  logic         key_last, data_last, mode_ok, commit;
  logic [4:0]   key_idx;
  logic [3:0]   data_idx;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  // A bit is taken on the synced rising edge of sclk while selected.
  assign sample   = sclk_s & ~sclk_hist & ~ss_s;
  assign ss_fall  = ~ss_s & ss_hist;
  assign ss_rise  = ss_s & ~ss_hist;
  assign in_frame = (state == MODE) || (state == KEY) || (state == DATA);

  assign rx_byte   = {shift, mosi_s};
  assign byte_done = sample & in_frame & (bit_cnt == 3'd7);
  assign mode_ok   = (rx_byte == 8'h00) || (rx_byte == 8'h01) || (rx_byte == 8'h02);
  assign key_bytes = {nk_stage, 2'b00};
  assign key_last  = ({1'b0, byte_cnt} == key_bytes - 6'd1);
  assign data_last = (byte_cnt == 5'd15);
  assign key_idx   = 5'd31 - byte_cnt;
  assign data_idx  = 4'd14 - byte_cnt[3:0];

  // Synchronize the asynchronous SPI pins and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      sclk_hist <= sclk_s;
      ss_hist   <= ss_s;
    end
  end

  // Frame sequencing: next state and the commit strobe.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: if (ss_fall) state_next = MODE;
      MODE: begin
        if (ss_rise)        state_next = ERR;
        else if (byte_done) state_next = mode_ok ? KEY : ERR;
      end
      KEY: begin
        if (ss_rise)                    state_next = ERR;
        else if (byte_done && key_last) state_next = DATA;
      end
      DATA: begin
        if (ss_rise) state_next = ERR;
        else if (byte_done && data_last) begin
          state_next = RUN;
          commit     = 1'b1;
        end
      end
      RUN:     if (flag) state_next = IDLE;
      ERR:     if (ss_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered cs/busy/frame_err decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cs        <= (state_next == RUN);
      busy      <= (state_next == MODE) || (state_next == KEY) ||
                   (state_next == DATA) || (state_next == RUN);
      frame_err <= (state_next == ERR) && (state != ERR);
    end
  end

  // Bit/byte assembly and staging of mode, key and plaintext; cleared outside a frame.
  always_ff @(posedge clk) begin
    if (rst || !in_frame) begin
      shift      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      nk_stage   <= '0;
      nr_stage   <= '0;
      key_stage  <= '0;
      init_stage <= '0;
    end else if (sample) begin
      shift   <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        case (state)
          MODE: begin
            case (rx_byte)
              8'h00:   begin nk_stage <= 4'd4; nr_stage <= 4'd10; end
              8'h01:   begin nk_stage <= 4'd6; nr_stage <= 4'd12; end
              8'h02:   begin nk_stage <= 4'd8; nr_stage <= 4'd14; end
              default: ;
            endcase
          end
          KEY: begin
            key_stage[{key_idx, 3'b000} +: 8] <= rx_byte;
            byte_cnt <= key_last ? 5'd0 : byte_cnt + 5'd1;
          end
          DATA: begin
            if (!data_last) init_stage[{data_idx, 3'b000} +: 8] <= rx_byte;
            byte_cnt <= byte_cnt + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Committed outputs change only when a complete, valid frame has arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      Nk   <= '0;
      Nr   <= '0;
      key  <= '0;
      init <= '0;
    end else if (commit) begin
      Nk   <= nk_stage;
      Nr   <= nr_stage;
      key  <= key_stage;
      init <= {init_stage, rx_byte};
    end
  end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Upstream stage of the AES datapath: SPI slave that receives a command frame (mode byte, key, plaintext) from an external host.
- Assembles the frame, then drives the Nk/Nr/key inputs of KeyExpansion and the init/cs inputs of Cipher.
- Holds cs high until Cipher raises flag, then releases and re-arms for the next frame.
- SPI mode 0 only: sample MOSI on SCLK rising edge, MSB first. All SPI inputs are oversampled in the clk domain.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizer on spi_sclk, spi_mosi and spi_ss_n (minimum 2)

Ports:
clk  input  1  system clock; must be at least 8x the spi_sclk frequency
rst  input  1  synchronous, active-high reset
spi_sclk  input  1  SPI serial clock, asynchronous to clk
spi_mosi  input  1  SPI data in
spi_ss_n  input  1  SPI slave select, active low
flag  input  1  Cipher done indication; level, sampled on clk
Nk  output  4  key length in words (4/6/8), to KeyExpansion
Nr  output  4  round count (10/12/14), to KeyExpansion and Cipher
key  output  256  cipher key, MSB-aligned; unused low bits are zero
init  output  128  plaintext block, to Cipher
cs  output  1  start/hold to Cipher
busy  output  1  high from first frame bit through cs release
frame_err  output  1  one-clk pulse on a protocol error

Behaviour:
- Reset values (clk edge with rst=1, regardless of state): Nk=0, Nr=0, key=0, init=0, cs=0, busy=0, frame_err=0, FSM=IDLE, bit/byte counters=0, shift registers=0.
- Sampling: spi_sclk and spi_ss_n each pass through SYNC_STAGES FFs plus one history FF. A bit is sampled when the synced sclk is 1 and the previous synced sclk is 0, provided synced ss_n=0. mosi uses the same sync depth.
- Byte assembly: 8 sampled bits, MSB first, form one byte; the byte counter then increments.
- FSM states: IDLE, MODE, KEY, DATA, RUN, ERR.
  - IDLE -> MODE: on a synced ss_n falling edge. busy=1 from this cycle.
  - MODE: the first byte selects the mode.
    - 0x00: Nk=4, Nr=10, 16 key bytes.
    - 0x01: Nk=6, Nr=12, 24 key bytes.
    - 0x02: Nk=8, Nr=14, 32 key bytes.
    - Any other value -> ERR.
  - KEY: key bytes shift into a 256-bit staging register MSB first and are left-aligned, i.e. byte 0 lands in bits [255:248]. Unused low bytes are 0. After the last key byte -> DATA.
  - DATA: 16 plaintext bytes, byte 0 in init[127:120]. On the clk after the 8th bit of byte 15 is sampled:
    - staging values are committed to Nk, Nr, key and init;
    - cs=1 in the same cycle;
    - FSM -> RUN.
    - Latency is exactly one clk from the final bit's sample cycle to cs=1.
  - RUN: cs held at 1 and outputs stable. SPI activity is ignored, including new ss_n edges and extra bits. On the first clk where flag=1:
    - cs=0 and busy=0 on the next edge;
    - FSM -> IDLE.
    - The committed outputs keep their values after release.
  - ERR: frame_err=1 for one clk, then wait for synced ss_n=1, then -> IDLE. busy=0 on entering ERR.
- ss_n rising edge mid-frame (MODE/KEY/DATA, including a partial byte) -> ERR (frame_err pulse). Outputs are not updated and staging is discarded.
- Extra bits after the final plaintext byte (still in RUN) are ignored. They do not affect outputs.
- A frame that is exactly complete, followed by ss_n high, is not an error.
- rst asserted in any state, including RUN with cs=1, returns everything to reset values on that edge. cs drops immediately.
- frame_err and the commit/cs rising edge can never occur in the same cycle.

Test Plan:
1. AES-256 frame: mode 0x02, key 000102..1f, pt 00112233445566778899aabbccddeeff.
   -> cs=1 one clk after the last bit is sampled; Nk=8, Nr=14, key=000102..1f, init=0011..eeff.
   -> With Cipher/KeyExpansion attached, Encrypted_Msg=8ea2b7ca516745bfeafc49904b496089 when flag rises; cs=0 and busy=0 the next clk.
2. AES-128 frame: mode 0x00, key 000102..0f, same pt.
   -> Nk=4, Nr=10, key=000102..0f followed by 128 zero bits.
   -> Cipher output 69c4e0d86a7b0430d8cdb78070b4c55a.
3. Bad mode byte 0x05 -> frame_err pulses exactly one clk; cs stays 0; outputs unchanged; a following valid frame completes normally.
4. ss_n raised after 20 bytes of an AES-256 frame (mid key) -> frame_err pulse; key/init keep their previous values; busy returns to 0.
5. Second frame sent while in RUN (flag held 0) -> ignored; cs stays 1 and outputs unchanged; after flag=1 a fresh frame is accepted.
6. rst pulsed for one clk while cs=1 -> all outputs 0 on the next edge; a subsequent AES-192 frame (mode 0x01) yields Nk=6, Nr=12.
